// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t       : FSM state encoding (IDLE=0, ADD=1, FIN=2)
//   DEFAULT_WIDTH : default operand width in bits
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder.
//   A, B : operand bits
//   CI   : carry in
//   S    : sum bit
//   CO   : carry out
module full_adder (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic S,
  output logic CO
);

  assign S  = A ^ B ^ CI;
  assign CO = (A & B) | (CI & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit unsigned operands plus a carry-in,
// one bit per clock, LSB first, and publishes {COUT,S} when done.
//   CLK   : clock, rising edge
//   RST   : asynchronous active-high reset
//   START : begin an addition (accepted in IDLE or FIN)
//   A, B  : operands, captured on accept
//   CIN   : carry-in, captured on accept
//   S     : registered sum of the last completed addition
//   COUT  : registered carry-out of the last completed addition
//   BUSY  : high while bits are being processed
//   DONE  : one-cycle pulse when S/COUT update
//
// state | meaning
// IDLE  | waiting for START
// ADD   | processing one operand bit per edge
// FIN   | result just published; DONE high, START may re-arm
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t          state;
  state_t          state_nxt;
  logic            accept;
  logic            last_bit;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic            carry;
  logic [CW-1:0]   bit_cnt;
  logic            fa_s;
  logic            fa_co;

  full_adder u_fa (
    .A  (a_sh[0]),
    .B  (b_sh[0]),
    .CI (carry),
    .S  (fa_s),
    .CO (fa_co)
  );

  assign last_bit = (bit_cnt == LAST_BIT);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          accept    = 1'b1;
          state_nxt = ADD;
        end
      end
      ADD: begin
        if (last_bit) state_nxt = FIN;
      end
      FIN: begin
        if (START) begin
          accept    = 1'b1;
          state_nxt = ADD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // a_sh doubles as the result register: each sum bit enters at the MSB
  // as the consumed operand bit leaves at the LSB, so after WIDTH shifts it
  // holds the sum. S itself is only loaded on the final bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
      S       <= '0;
      COUT    <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state <= state_nxt;
      BUSY  <= (state_nxt == ADD);
      DONE  <= (state_nxt == FIN);
      if (accept) begin
        a_sh    <= A;
        b_sh    <= B;
        carry   <= CIN;
        bit_cnt <= '0;
      end else if (state == ADD) begin
        a_sh  <= {fa_s, a_sh[WIDTH-1:1]};
        b_sh  <= b_sh >> 1;
        carry <= fa_co;
        if (!last_bit) begin
          bit_cnt <= bit_cnt + CW'(1);
        end else begin
          S    <= {fa_s, a_sh[WIDTH-1:1]};
          COUT <= fa_co;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic       clk;
  logic       rst;

  logic       start8, cin8, cout8, busy8, done8;
  logic [7:0] a8, b8, s8;

  logic       start2, cin2, cout2, busy2, done2;
  logic [1:0] a2, b2, s2;

  int checks   = 0;
  int failures = 0;

  logic [63:0] last8, last2, cur_res;
  logic [63:0] cur_a, cur_b, cur_cin;
  bit          prev_b2b, b2b;

  serial_adder #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .START(start8), .A(a8), .B(b8), .CIN(cin8),
    .S(s8), .COUT(cout8), .BUSY(busy8), .DONE(done8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .CLK(clk), .RST(rst), .START(start2), .A(a2), .B(b2), .CIN(cin2),
    .S(s2), .COUT(cout2), .BUSY(busy2), .DONE(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] res_obs(input int w);
    if (w == 8) return {55'b0, cout8, s8};
    else        return {61'b0, cout2, s2};
  endfunction

  function automatic logic busy_obs(input int w);
    return (w == 8) ? busy8 : busy2;
  endfunction

  function automatic logic done_obs(input int w);
    return (w == 8) ? done8 : done2;
  endfunction

  function automatic logic [63:0] last_of(input int w);
    return (w == 8) ? last8 : last2;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 8) start8 = v;
    else        start2 = v;
  endtask

  // Reference: {COUT,S} = A + B + CIN as plain unsigned arithmetic.
  task automatic start_op(input int w, input logic [63:0] a, input logic [63:0] b, input logic cin);
    cur_a   = a;
    cur_b   = b;
    cur_cin = {63'b0, cin};
    cur_res = a + b + {63'b0, cin};
    if (w == 8) begin
      a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; start8 = 1'b1;
    end else begin
      a2 = a[1:0]; b2 = b[1:0]; cin2 = cin; start2 = 1'b1;
    end
  endtask

  task automatic scramble(input int w, input bit hold_start);
    if (w == 8) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      start8 = hold_start ? 1'b1 : 1'($urandom);
    end else begin
      a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
      start2 = hold_start ? 1'b1 : 1'($urandom);
    end
  endtask

  task automatic finish_op(input int w, input bit keep_start);
    for (int i = 1; i <= w; i++) begin
      @(negedge clk);
      check("busy_in_add", {63'b0, busy_obs(w)}, 64'd1);
      check("done_early", {63'b0, done_obs(w)}, 64'd0);
      check("s_hold_in_add", res_obs(w), last_of(w));
      scramble(w, keep_start);
    end
    @(negedge clk);
    check("done_pulse", {63'b0, done_obs(w)}, 64'd1);
    check("busy_in_fin", {63'b0, busy_obs(w)}, 64'd0);
    check($sformatf("sum w=%0d a=%0h b=%0h cin=%0d", w, cur_a, cur_b, cur_cin),
          res_obs(w), cur_res);
    if (w == 8) last8 = cur_res;
    else        last2 = cur_res;
    if (!keep_start) set_start(w, 1'b0);
  endtask

  task automatic idle_op(input int w);
    @(negedge clk);
    check("done_one_cycle", {63'b0, done_obs(w)}, 64'd0);
    check("busy_idle", {63'b0, busy_obs(w)}, 64'd0);
    check("s_hold_idle", res_obs(w), last_of(w));
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    last8 = '0; last2 = '0;

    #1;
    check("reset_res8", res_obs(8), 64'd0);
    check("reset_busy8", {63'b0, busy8}, 64'd0);
    check("reset_done8", {63'b0, done8}, 64'd0);
    check("reset_res2", res_obs(2), 64'd0);

    // First START right after reset release, then the directed vectors.
    @(negedge clk);
    rst = 1'b0;
    start_op(8, 64'h00, 64'h00, 1'b0);
    finish_op(8, 1'b0);
    idle_op(8);
    start_op(8, 64'hFF, 64'h01, 1'b0);
    finish_op(8, 1'b0);
    idle_op(8);
    start_op(8, 64'hA5, 64'h5A, 1'b1);
    finish_op(8, 1'b0);
    idle_op(8);
    start_op(8, 64'h3C, 64'h42, 1'b0);
    finish_op(8, 1'b0);

    // START held high: back-to-back accepts, operands churned mid-ADD.
    idle_op(8);
    start_op(8, 64'h12, 64'h34, 1'b1);
    finish_op(8, 1'b1);
    start_op(8, 64'hF0, 64'h0F, 1'b1);
    finish_op(8, 1'b1);
    start_op(8, 64'h80, 64'h80, 1'b0);
    finish_op(8, 1'b0);

    // Asynchronous reset in the 4th ADD cycle aborts the addition.
    idle_op(8);
    start_op(8, 64'hAB, 64'hCD, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    check("abort_res8", res_obs(8), 64'd0);
    check("abort_busy8", {63'b0, busy8}, 64'd0);
    check("abort_done8", {63'b0, done8}, 64'd0);
    #1 rst = 1'b0;
    last8 = '0;
    last2 = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("no_done_after_abort", {63'b0, done8}, 64'd0);
      check("res_after_abort", res_obs(8), 64'd0);
    end
    start_op(8, 64'h10, 64'h20, 1'b0);
    finish_op(8, 1'b0);

    // Random operands against the arithmetic reference, both widths.
    prev_b2b = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      if (!prev_b2b) idle_op(8);
      start_op(8, 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)), 1'($urandom));
      b2b = (n != 999) && ($urandom_range(0, 1) == 1);
      finish_op(8, b2b);
      prev_b2b = b2b;
    end

    prev_b2b = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      if (!prev_b2b) idle_op(2);
      start_op(2, 64'($urandom_range(0, 3)), 64'($urandom_range(0, 3)), 1'($urandom));
      b2b = (n != 999) && ($urandom_range(0, 1) == 1);
      finish_op(2, b2b);
      prev_b2b = b2b;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
